// File: rtl/serial_cmd_frontend.sv
// UART byte-frame parser feeding a command FIFO for the SDRAM arbiter, plus a
// response FIFO drained back out through the UART transmitter.
module serial_cmd_frontend #(
    parameter int CMD_DEPTH     = 8,
    parameter int RSP_DEPTH     = 8,
    parameter int FRAME_TIMEOUT = 4000
) (
    input  logic        clk2M,
    input  logic        nReset,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    input  logic        txReady,
    output logic        txStart,
    output logic [7:0]  txData,
    input  logic        fifoReadStrobe,
    output logic        fifoDataEmpty,
    output logic        writeSDRAM,
    output logic [15:0] cmdAddr,
    output logic [7:0]  cmdData,
    input  logic        fifoWriteStrobe,
    input  logic [7:0]  sdramReadData,
    output logic        fifoDataFull,
    output logic        frameError,
    output logic        cmdOverflow,
    output logic        rspOverflow
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CAW:0]  CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0]  RSP_FULL = (RAW+1)'(RSP_DEPTH);
    localparam logic [TW-1:0] TO_MAX   = TW'(FRAME_TIMEOUT - 1);

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef enum logic [1:0] {P_IDLE, P_ADDR_HI, P_ADDR_LO, P_DATA} pState_t;
    typedef enum logic [1:0] {T_IDLE, T_WAIT_LOW, T_WAIT_HIGH} tState_t;

    pState_t       pState;
    tState_t       tState;
    logic          frameWe;
    logic [15:0]   frameAddr;
    logic [TW-1:0] toCnt;

    cmd_t          cmdMem [CMD_DEPTH];
    logic [CAW-1:0] cmdWr, cmdRd, cmdRdNext;
    logic [CAW:0]  cmdCount, cmdCountNext;
    cmd_t          pushEntry, headNext;
    logic          frameDone, cmdPush, cmdPop;

    logic [7:0]    rspMem [RSP_DEPTH];
    logic [RAW-1:0] rspWr, rspRd;
    logic [RAW:0]  rspCount, rspCountNext;
    logic          rspPush, rspPop;

    // The final byte of a frame is pushed straight from rxData on the accepting edge.
    always_comb begin
        frameDone      = rxValid && ((pState == P_ADDR_LO && !frameWe) || pState == P_DATA);
        pushEntry.we   = frameWe;
        pushEntry.addr = (pState == P_DATA) ? frameAddr : {frameAddr[15:8], rxData};
        pushEntry.data = (pState == P_DATA) ? rxData : 8'h00;
        cmdPush        = frameDone && (cmdCount != CMD_FULL);
        cmdPop         = fifoReadStrobe && (cmdCount != '0);
        cmdRdNext      = cmdRd + CAW'(cmdPop);
        cmdCountNext   = cmdCount + (CAW+1)'(cmdPush) - (CAW+1)'(cmdPop);
        // The slot being written this edge becomes the head only when the FIFO drains to it.
        headNext       = (cmdPush && cmdRdNext == cmdWr) ? pushEntry : cmdMem[cmdRdNext];
        rspPush        = fifoWriteStrobe && (rspCount != RSP_FULL);
        rspPop         = (tState == T_IDLE) && (rspCount != '0) && txReady;
        rspCountNext   = rspCount + (RAW+1)'(rspPush) - (RAW+1)'(rspPop);
    end

    always_ff @(posedge clk2M) begin
        if (!nReset) begin
            pState      <= P_IDLE;
            frameWe     <= 1'b0;
            frameAddr   <= '0;
            toCnt       <= '0;
            frameError  <= 1'b0;
            cmdOverflow <= 1'b0;
        end else begin
            if (frameDone && cmdCount == CMD_FULL)
                cmdOverflow <= 1'b1;
            if (rxValid) begin
                toCnt <= '0;
                case (pState)
                    P_IDLE: begin
                        if (rxData == 8'h57) begin
                            frameWe <= 1'b1;
                            pState  <= P_ADDR_HI;
                        end else if (rxData == 8'h52) begin
                            frameWe <= 1'b0;
                            pState  <= P_ADDR_HI;
                        end else begin
                            frameError <= 1'b1;
                        end
                    end
                    P_ADDR_HI: begin
                        frameAddr[15:8] <= rxData;
                        pState          <= P_ADDR_LO;
                    end
                    P_ADDR_LO: begin
                        frameAddr[7:0] <= rxData;
                        pState         <= frameWe ? P_DATA : P_IDLE;
                    end
                    default: pState <= P_IDLE;
                endcase
            end else if (pState == P_IDLE) begin
                toCnt <= '0;
            end else if (toCnt == TO_MAX) begin
                pState     <= P_IDLE;
                frameError <= 1'b1;
                toCnt      <= '0;
            end else begin
                toCnt <= toCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk2M) begin
        if (cmdPush) cmdMem[cmdWr] <= pushEntry;
        if (rspPush) rspMem[rspWr] <= sdramReadData;
    end

    always_ff @(posedge clk2M) begin
        if (!nReset) begin
            cmdWr         <= '0;
            cmdRd         <= '0;
            cmdCount      <= '0;
            fifoDataEmpty <= 1'b1;
            writeSDRAM    <= 1'b0;
            cmdAddr       <= '0;
            cmdData       <= '0;
        end else begin
            cmdWr         <= cmdWr + CAW'(cmdPush);
            cmdRd         <= cmdRdNext;
            cmdCount      <= cmdCountNext;
            fifoDataEmpty <= (cmdCountNext == '0);
            if (cmdCountNext != '0)
                {writeSDRAM, cmdAddr, cmdData} <= headNext;
        end
    end

    always_ff @(posedge clk2M) begin
        if (!nReset) begin
            rspWr        <= '0;
            rspRd        <= '0;
            rspCount     <= '0;
            fifoDataFull <= 1'b0;
            rspOverflow  <= 1'b0;
            tState       <= T_IDLE;
            txStart      <= 1'b0;
            txData       <= '0;
        end else begin
            rspWr        <= rspWr + RAW'(rspPush);
            rspRd        <= rspRd + RAW'(rspPop);
            rspCount     <= rspCountNext;
            fifoDataFull <= (rspCountNext == RSP_FULL);
            if (fifoWriteStrobe && rspCount == RSP_FULL)
                rspOverflow <= 1'b1;
            txStart <= 1'b0;
            case (tState)
                T_IDLE: if (rspPop) begin
                    txData  <= rspMem[rspRd];
                    txStart <= 1'b1;
                    tState  <= T_WAIT_LOW;
                end
                T_WAIT_LOW:  if (!txReady) tState <= T_WAIT_HIGH;
                T_WAIT_HIGH: if (txReady)  tState <= T_IDLE;
                default:     tState <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmd_frontend.sv
// Directed bench for serial_cmd_frontend: frame parsing, FIFO ordering,
// timeout, overflow flags and transmit handshake.
module tb_serial_cmd_frontend;
    localparam int TO = 4000;

    logic        clk2M = 1'b0;
    logic        nReset, rxValid, txReady, txStart;
    logic [7:0]  rxData, txData, cmdData, sdramReadData;
    logic        fifoReadStrobe, fifoDataEmpty, writeSDRAM;
    logic [15:0] cmdAddr;
    logic        fifoWriteStrobe, fifoDataFull, frameError, cmdOverflow, rspOverflow;

    int nChecks = 0;
    int nFails  = 0;

    serial_cmd_frontend #(.CMD_DEPTH(8), .RSP_DEPTH(8), .FRAME_TIMEOUT(TO)) dut (
        .clk2M(clk2M), .nReset(nReset), .rxValid(rxValid), .rxData(rxData),
        .txReady(txReady), .txStart(txStart), .txData(txData),
        .fifoReadStrobe(fifoReadStrobe), .fifoDataEmpty(fifoDataEmpty),
        .writeSDRAM(writeSDRAM), .cmdAddr(cmdAddr), .cmdData(cmdData),
        .fifoWriteStrobe(fifoWriteStrobe), .sdramReadData(sdramReadData),
        .fifoDataFull(fifoDataFull), .frameError(frameError),
        .cmdOverflow(cmdOverflow), .rspOverflow(rspOverflow)
    );

    always #5 clk2M = ~clk2M;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2M);
        #1;
    endtask

    task automatic doReset();
        nReset = 1'b0; rxValid = 1'b0; rxData = '0; txReady = 1'b0;
        fifoReadStrobe = 1'b0; fifoWriteStrobe = 1'b0; sdramReadData = '0;
        tick(); tick();
        nReset = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxData = b; rxValid = 1'b1;
        tick();
        rxValid = 1'b0;
    endtask

    task automatic pop();
        fifoReadStrobe = 1'b1;
        tick();
        fifoReadStrobe = 1'b0;
    endtask

    initial begin
        int pulses;
        int fullSeen;
        logic [7:0] txSeen;

        doReset();
        check("rst empty", fifoDataEmpty, 1);
        check("rst full", fifoDataFull, 0);
        check("rst txStart", txStart, 0);
        check("rst txData", txData, 0);
        check("rst head", {writeSDRAM, cmdAddr, cmdData}, 0);
        check("rst flags", {frameError, cmdOverflow, rspOverflow}, 0);

        // write frame
        sendByte(8'h57); sendByte(8'h12); sendByte(8'h34);
        check("wr empty before last", fifoDataEmpty, 1);
        sendByte(8'hA5);
        check("wr empty", fifoDataEmpty, 0);
        check("wr we", writeSDRAM, 1);
        check("wr addr", cmdAddr, 16'h1234);
        check("wr data", cmdData, 8'hA5);
        pop();
        check("wr popped", fifoDataEmpty, 1);

        // read frame and one response byte
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h10);
        check("rd empty", fifoDataEmpty, 0);
        check("rd we", writeSDRAM, 0);
        check("rd addr", cmdAddr, 16'h0010);
        check("rd data", cmdData, 8'h00);
        pop();
        txReady = 1'b1;
        fifoWriteStrobe = 1'b1; sdramReadData = 8'h3C;
        tick();
        fifoWriteStrobe = 1'b0;
        pulses = 0; fullSeen = 0; txSeen = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (txStart) begin pulses++; txSeen = txData; end
            if (fifoDataFull) fullSeen = 1;
        end
        check("rsp pulses", pulses, 1);
        check("rsp txData", txSeen, 8'h3C);
        check("rsp full", fullSeen, 0);

        // bad opcode then a good frame
        doReset();
        sendByte(8'h41);
        check("badop err", frameError, 1);
        check("badop empty", fifoDataEmpty, 1);
        sendByte(8'h57); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h01);
        check("badop head", {writeSDRAM, cmdAddr, cmdData}, {1'b1, 16'hFFFF, 8'h01});
        pop();
        check("badop single", fifoDataEmpty, 1);

        // timeout discards partial frame
        doReset();
        sendByte(8'h57); sendByte(8'h01);
        repeat (TO) tick();
        check("to err", frameError, 1);
        check("to nothing", fifoDataEmpty, 1);
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h02);
        check("to head", {writeSDRAM, cmdAddr, cmdData}, {1'b0, 16'h0002, 8'h00});
        pop();
        check("to single", fifoDataEmpty, 1);

        // command FIFO overflow and ordering
        doReset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("cmdovf before", cmdOverflow, 0);
            sendByte(8'h57); sendByte(8'h00); sendByte(8'(i)); sendByte(8'(i + 8'h10));
        end
        check("cmdovf set", cmdOverflow, 1);
        for (int i = 0; i < 8; i++) begin
            check("ord empty", fifoDataEmpty, 0);
            check("ord head", {writeSDRAM, cmdAddr, cmdData}, {1'b1, 16'(i), 8'(i + 8'h10)});
            pop();
        end
        check("ord drained", fifoDataEmpty, 1);

        // response FIFO overflow and in-order transmit
        doReset();
        for (int i = 0; i < 9; i++) begin
            fifoWriteStrobe = 1'b1; sdramReadData = 8'(8'h80 + i);
            tick();
            if (i == 6) check("rsp not full", fifoDataFull, 0);
            if (i == 7) begin
                check("rsp full8", fifoDataFull, 1);
                check("rspovf before", rspOverflow, 0);
            end
        end
        fifoWriteStrobe = 1'b0;
        check("rspovf set", rspOverflow, 1);
        for (int k = 0; k < 8; k++) begin
            txReady = 1'b1;
            for (int w = 0; w < 20 && !txStart; w++) tick();
            check("tx start seen", txStart, 1);
            check("tx order", txData, 8'(8'h80 + k));
            txReady = 1'b0;
            tick();
            check("tx data held", txData, 8'(8'h80 + k));
        end
        txReady = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (txStart) pulses++;
        end
        check("tx no extra", pulses, 0);
        check("rsp full after", fifoDataFull, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/serial_cmd_frontend.md
Name: serial_cmd_frontend

Overview:
Serial-protocol front end sitting between the UART byte interface and the SDRAM FIFO arbiter. Parses incoming byte frames into SDRAM read/write commands and queues them in a command FIFO. The arbiter pops that FIFO via fifoReadStrobe. SDRAM read results pushed by the arbiter via fifoWriteStrobe are queued in a response FIFO and streamed back out through the UART transmitter.

Parameters:
CMD_DEPTH, 8, command FIFO entries; power of 2, minimum 2
RSP_DEPTH, 8, response FIFO entries; power of 2, minimum 2
FRAME_TIMEOUT, 4000, clk2M cycles allowed between bytes of one frame before the partial frame is discarded

Ports:
clk2M  in  1  system clock; all logic on rising edge
nReset  in  1  synchronous, active-low reset
rxValid  in  1  one-cycle pulse: rxData holds a received byte
rxData  in  8  received UART byte
txReady  in  1  UART transmitter idle
txStart  out  1  one-cycle pulse: transmit txData
txData  out  8  byte to transmit; held stable from txStart until txReady rises again
fifoReadStrobe  in  1  arbiter pop request for the command FIFO
fifoDataEmpty  out  1  command FIFO empty
writeSDRAM  out  1  head command type: 1 = write, 0 = read
cmdAddr  out  16  head command address
cmdData  out  8  head command write data; 0 for read commands
fifoWriteStrobe  in  1  arbiter push of sdramReadData into the response FIFO
sdramReadData  in  8  SDRAM read result
fifoDataFull  out  1  response FIFO full
frameError  out  1  sticky: bad opcode or frame timeout
cmdOverflow  out  1  sticky: complete frame dropped because the command FIFO was full
rspOverflow  out  1  sticky: fifoWriteStrobe arrived while the response FIFO was full

Behaviour:
- Reset (nReset=0 at an edge):
  - Parser goes to P_IDLE.
  - Both FIFOs empty: fifoDataEmpty=1, fifoDataFull=0.
  - writeSDRAM, cmdAddr, cmdData, txStart, txData all 0; all sticky flags 0; timeout counter 0.
  - Reset mid-frame or mid-transmit discards all in-flight state.
- Frame formats:
  - Write: 0x57, addrHi, addrLo, data.
  - Read: 0x52, addrHi, addrLo.
- Parser FSM. A state changes only on a cycle with rxValid=1, except on timeout.
  - P_IDLE: 0x57 -> P_ADDR_HI with we=1; 0x52 -> P_ADDR_HI with we=0; any other byte sets frameError and stays in P_IDLE.
  - P_ADDR_HI: latch addr[15:8] -> P_ADDR_LO.
  - P_ADDR_LO: latch addr[7:0]. If we=0, push {0, addr, 0x00} and go to P_IDLE; otherwise go to P_DATA.
  - P_DATA: push {1, addr, rxData} -> P_IDLE.
- Push timing: the entry is written at the edge that accepts the final byte; fifoDataEmpty falls the following cycle.
  - If the command FIFO is full (CMD_DEPTH entries) at push time, the frame is dropped and cmdOverflow is set.
- Timeout:
  - The counter clears on every rxValid and while in P_IDLE; otherwise it increments.
  - On reaching FRAME_TIMEOUT-1 the parser goes to P_IDLE, frameError is set, and the partial frame is discarded.
- Command FIFO read side (first-word-fall-through):
  - writeSDRAM/cmdAddr/cmdData are registered and show the head entry whenever fifoDataEmpty=0.
  - fifoReadStrobe=1 with non-empty FIFO: head advances at that edge; the next entry (or empty status) is visible the following cycle.
  - The arbiter samples two cycles after its strobe; outputs must be stable by then.
  - fifoReadStrobe while empty is ignored, no flag.
  - Simultaneous push and pop: both performed, count unchanged. When the FIFO is empty, a push followed by a pop in the next cycle is legal.
  - Pointers wrap modulo depth. Count width is log2(depth)+1, so a full FIFO is distinguished from an empty one.
- Response FIFO:
  - fifoWriteStrobe=1 pushes sdramReadData at that edge.
  - fifoDataFull is registered, equal to (count==RSP_DEPTH).
  - A push while full is dropped and sets rspOverflow.
  - Simultaneous push and transmitter pop are allowed.
- Transmit FSM:
  - T_IDLE: response FIFO non-empty and txReady=1 -> drive txData=head, pulse txStart for exactly one cycle, pop head -> T_WAIT_LOW.
  - T_WAIT_LOW: wait for txReady=0 -> T_WAIT_HIGH.
  - T_WAIT_HIGH: wait for txReady=1 -> T_IDLE.
  - Minimum spacing between txStart pulses is 3 cycles.
- Sticky flags clear only on reset.

Test Plan:
- Reset, then bytes 0x57,0x12,0x34,0xA5 -> fifoDataEmpty=0 the cycle after the 4th byte; writeSDRAM=1, cmdAddr=0x1234, cmdData=0xA5; one fifoReadStrobe -> fifoDataEmpty=1 next cycle.
- Bytes 0x52,0x00,0x10 then fifoWriteStrobe with sdramReadData=0x3C, txReady=1 -> writeSDRAM=0, cmdAddr=0x0010, cmdData=0x00; exactly one txStart pulse with txData=0x3C; fifoDataFull stays 0.
- Byte 0x41, then 0x57,0xFF,0xFF,0x01 -> frameError=1; one command queued with cmdAddr=0xFFFF, cmdData=0x01.
- Bytes 0x57,0x01, then FRAME_TIMEOUT idle cycles, then 0x52,0x00,0x02 -> frameError=1; only the read command is queued, at address 0x0002.
- Nine write frames with no pops (CMD_DEPTH=8) -> eight entries popped in order with addresses 0..7; cmdOverflow=1.
- Nine fifoWriteStrobe pushes with txReady=0 -> fifoDataFull=1 after the 8th push; rspOverflow=1 after the 9th. Then toggle txReady -> 8 bytes sent in push order.
